// File: rtl/blur_pkg.sv
// Shared types and arithmetic for the blur stages (horizontal and vertical).
package blur_pkg;

    localparam logic [2:0] MODE_BLUR = 3'b101;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef logic [23:0] rgb_t;

    function automatic logic [7:0] avg4(input logic [7:0] p0, input logic [7:0] p1,
                                        input logic [7:0] p2, input logic [7:0] p3);
        logic [9:0] sum;
        sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
        return sum[9:2];
    endfunction

    // Row-buffer selector steps 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] sel_next(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/verblur_linebuf.sv
// One row of RGB history: asynchronous read, synchronous write; contents are never reset.
module verblur_linebuf
    import blur_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = 640,
    parameter int unsigned COL_W     = $clog2(IMG_WIDTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [COL_W-1:0] addr_i,
    input  rgb_t             wdata_i,
    output rgb_t             rdata_o
);

    rgb_t mem [IMG_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/verblur.sv
// Vertical 4-tap box blur over three rotating row buffers, one output register stage.
// Optional VERBLUR_EDGE_REPLICATE_EN: invalid top-of-frame taps take the input pixel instead of 0.
module verblur
    import blur_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = 640
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        frame_start,
    input  logic [2:0]  mode_wb,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pix,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pix,
    output logic        out_eol
);

    localparam int unsigned      COL_W    = $clog2(IMG_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    pixel_t           pix;
    rgb_t             in_rgb;
    rgb_t             fill;
    rgb_t             rd [3];
    rgb_t             tap1, tap2, tap3;
    rgb_t             blur_rgb;
    logic             accept, blur, wr_en;
    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [1:0]       ws_q, ws_d, ws_cur, ws1, ws2;
    logic [1:0]       rs_q, rs_d, rs_cur;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_pix_q, out_pix_d;
    logic             out_eol_q, out_eol_d;
    logic             unused_alpha;

    assign pix          = in_pix;
    assign in_rgb       = {pix.r, pix.g, pix.b};
    assign unused_alpha = ^pix.a;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign blur     = (mode_wb == MODE_BLUR);
    assign wr_en    = accept && blur;

    // frame_start takes effect for the pixel accepted in the same cycle.
    assign col_cur = frame_start ? '0 : col_q;
    assign ws_cur  = frame_start ? '0 : ws_q;
    assign rs_cur  = frame_start ? '0 : rs_q;
    assign ws1     = sel_next(ws_cur);
    assign ws2     = sel_next(ws1);

    for (genvar i = 0; i < 3; i++) begin : g_lb
        verblur_linebuf #(
            .IMG_WIDTH (IMG_WIDTH),
            .COL_W     (COL_W)
        ) u_lb (
            .clk     (clk),
            .we_i    (wr_en && (ws_cur == 2'(i))),
            .addr_i  (col_cur),
            .wdata_i (in_rgb),
            .rdata_o (rd[i])
        );
    end

`ifdef VERBLUR_EDGE_REPLICATE_EN
    assign fill = in_rgb;
`else
    assign fill = '0;
`endif

    always_comb begin
        tap1 = (rs_cur >= 2'd1) ? rd[ws2] : fill;
        tap2 = (rs_cur >= 2'd2) ? rd[ws1] : fill;
        tap3 = (rs_cur >= 2'd3) ? rd[ws_cur] : fill;
        blur_rgb = {avg4(in_rgb[23:16], tap1[23:16], tap2[23:16], tap3[23:16]),
                    avg4(in_rgb[15:8],  tap1[15:8],  tap2[15:8],  tap3[15:8]),
                    avg4(in_rgb[7:0],   tap1[7:0],   tap2[7:0],   tap3[7:0])};
    end

    always_comb begin
        col_d       = col_cur;
        ws_d        = ws_cur;
        rs_d        = rs_cur;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        out_eol_d   = out_eol_q;
        if (accept) begin
            out_valid_d = 1'b1;
            if (blur) begin
                out_pix_d = {8'hFF, blur_rgb};
                if (col_cur == LAST_COL) begin
                    out_eol_d = 1'b1;
                    col_d     = '0;
                    ws_d      = ws1;
                    rs_d      = (rs_cur == 2'd3) ? 2'd3 : rs_cur + 2'd1;
                end else begin
                    out_eol_d = 1'b0;
                    col_d     = col_cur + COL_W'(1);
                end
            end else begin
                out_pix_d = {8'hFF, in_rgb};
                out_eol_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            col_q       <= '0;
            ws_q        <= '0;
            rs_q        <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_eol_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            ws_q        <= ws_d;
            rs_q        <= rs_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_eol_q   <= out_eol_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_eol   = out_eol_q;

endmodule
